// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: per-frame shadow capture,
// divided digit scan, hex decode, blanking and leading-zero suppression.
module seg7_scan_driver #(
    parameter  int DIGITS      = 4,
    parameter  int REFRESH_DIV = 50000,
    localparam int IDXW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    output logic [6:0]            a_to_g,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic [IDXW-1:0]       digit_idx,
    output logic                  frame_start
);

    localparam int DIVW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        S_OFF,
        S_LOAD,
        S_SCAN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DIVW-1:0]       r_div;
    logic [IDXW-1:0]       r_idx;
    logic [4*DIGITS-1:0]   r_sh_val;
    logic [DIGITS-1:0]     r_sh_dp;
    logic [DIGITS-1:0]     r_sh_blank;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_an;

    logic                  w_tick;
    logic                  w_last;
    logic                  w_capture;
    logic [DIGITS-1:0]     w_zero_from;
    logic [DIGITS-1:0]     w_onehot;
    logic [3:0]            w_nib;
    logic                  w_dpi;
    logic                  w_blk;
    logic                  w_supp;
    logic [6:0]            w_seg_n;
    logic                  w_dp_n;
    logic [DIGITS-1:0]     w_an_n;

    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        case (n)
            4'h0:    f_hex7 = 7'b0000001;
            4'h1:    f_hex7 = 7'b1001111;
            4'h2:    f_hex7 = 7'b0010010;
            4'h3:    f_hex7 = 7'b0000110;
            4'h4:    f_hex7 = 7'b1001100;
            4'h5:    f_hex7 = 7'b0100100;
            4'h6:    f_hex7 = 7'b0100000;
            4'h7:    f_hex7 = 7'b0001111;
            4'h8:    f_hex7 = 7'b0000000;
            4'h9:    f_hex7 = 7'b0000100;
            4'hA:    f_hex7 = 7'b0001000;
            4'hB:    f_hex7 = 7'b1100000;
            4'hC:    f_hex7 = 7'b0110001;
            4'hD:    f_hex7 = 7'b1000010;
            4'hE:    f_hex7 = 7'b0110000;
            default: f_hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_tick    = (r_div == DIVW'(REFRESH_DIV - 1));
        w_last    = (r_idx == IDXW'(DIGITS - 1));
        if (!en) begin
            w_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF:  w_next = S_LOAD;
                S_LOAD: begin
                    w_next    = S_SCAN;
                    w_capture = 1'b1;
                end
                S_SCAN: begin
                    // Reload on the last digit's final cycle so the next frame starts clean
                    if (w_tick && w_last) begin
                        w_capture = 1'b1;
                    end
                end
                default: w_next = S_OFF;
            endcase
        end
    end

    always_comb begin
        w_zero_from = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_zero_from[i] = 1'b1;
            for (int unsigned j = i; j < DIGITS; j++) begin
                if (r_sh_val[4*j +: 4] != 4'h0) begin
                    w_zero_from[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_nib    = 4'h0;
        w_dpi    = 1'b0;
        w_blk    = 1'b0;
        w_supp   = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_onehot[i] = 1'b1;
                w_nib       = r_sh_val[4*i +: 4];
                w_dpi       = r_sh_dp[i];
                w_blk       = r_sh_blank[i];
                w_supp      = (i != 0) && w_zero_from[i];
            end
        end
    end

    always_comb begin
        w_seg_n = '1;
        w_dp_n  = 1'b1;
        w_an_n  = '1;
        if (r_state == S_SCAN && en && !w_blk) begin
            if (lz_suppress && w_supp) begin
                // Suppressed digit still shows a requested dp (e.g. ".5")
                if (w_dpi) begin
                    w_an_n = ~w_onehot;
                    w_dp_n = 1'b0;
                end
            end else begin
                w_an_n  = ~w_onehot;
                w_seg_n = f_hex7(w_nib);
                w_dp_n  = ~w_dpi;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_OFF;
            r_div      <= '0;
            r_idx      <= '0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_seg      <= '1;
            r_dp       <= 1'b1;
            r_an       <= '1;
        end else begin
            r_state <= w_next;
            r_seg   <= w_seg_n;
            r_dp    <= w_dp_n;
            r_an    <= w_an_n;
            if (w_capture) begin
                r_sh_val   <= value;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank;
            end
            if (r_state == S_SCAN && w_next == S_SCAN) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_idx <= w_last ? '0 : r_idx + IDXW'(1);
                end else begin
                    r_div <= r_div + DIVW'(1);
                end
            end else begin
                r_div <= '0;
                r_idx <= '0;
            end
        end
    end

    assign a_to_g      = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign digit_idx   = r_idx;
    assign frame_start = w_capture;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model pushes
// expected pin states per cycle; a negedge monitor pops and compares.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        en = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  a_to_g;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_start;

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .clr_n(clr_n), .en(en), .value(value), .dp_in(dp_in),
        .blank(blank), .lz_suppress(lz), .a_to_g(a_to_g), .dp(dp), .an(an),
        .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: mode 0=off, 1=load, 2=scanning; m_t counts cycles into the frame
    int         m_mode = 0;
    int         m_t = 0;
    logic [3:0] m_nib [D];
    logic [3:0] m_dp = '0;
    logic [3:0] m_blk = '0;
    logic [3:0] o_an;
    logic [6:0] o_seg;
    logic       o_dp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_t = 0;
        m_dp = '0;
        m_blk = '0;
        for (int j = 0; j < D; j++) m_nib[j] = 4'h0;
    endtask

    task automatic capture();
        for (int j = 0; j < D; j++) m_nib[j] = value[4*j +: 4];
        m_dp = dp_in;
        m_blk = blank;
    endtask

    task automatic look(input int k, output logic [3:0] a, output logic [6:0] s, output logic d);
        bit zeros;
        a = 4'hF;
        s = 7'h7F;
        d = 1'b1;
        zeros = 1'b1;
        for (int j = k; j < D; j++) if (m_nib[j] != 4'h0) zeros = 1'b0;
        if (!m_blk[k]) begin
            if (lz && k > 0 && zeros) begin
                if (m_dp[k]) begin
                    a = ~(4'b0001 << k);
                    d = 1'b0;
                end
            end else begin
                a = ~(4'b0001 << k);
                s = seg_tab[m_nib[k]];
                d = ~m_dp[k];
            end
        end
    endtask

    task automatic step_model();
        if (m_mode == 2 && en) begin
            look((m_t / R) % D, o_an, o_seg, o_dp);
        end else begin
            o_an = 4'hF;
            o_seg = 7'h7F;
            o_dp = 1'b1;
        end
        if (!en) begin
            m_mode = 0;
            m_t = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            capture();
            m_mode = 2;
            m_t = 0;
        end else if (m_t == R*D - 1) begin
            capture();
            m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic tick(input logic n_en, input logic [15:0] n_val, input logic [3:0] n_dp,
                        input logic [3:0] n_blk, input logic n_lz);
        exp_t e;
        @(posedge clk);
        step_model();
        #1;
        en = n_en;
        value = n_val;
        dp_in = n_dp;
        blank = n_blk;
        lz = n_lz;
        e.an = o_an;
        e.seg = o_seg;
        e.dp = o_dp;
        e.idx = (m_mode == 2) ? 2'((m_t / R) % D) : 2'd0;
        e.fs = en && (m_mode == 1 || (m_mode == 2 && m_t == R*D - 1));
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic n_en, input logic [15:0] n_val,
                       input logic [3:0] n_dp, input logic [3:0] n_blk, input logic n_lz);
        for (int c = 0; c < n; c++) tick(n_en, n_val, n_dp, n_blk, n_lz);
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_an"}, 32'(an), 32'hF);
        chk({nm, "_seg"}, 32'(a_to_g), 32'h7F);
        chk({nm, "_dp"}, 32'(dp), 32'h1);
        chk({nm, "_fs"}, 32'(frame_start), 32'h0);
        chk({nm, "_idx"}, 32'(digit_idx), 32'h0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("an", 32'(an), 32'(e.an));
            chk("seg", 32'(a_to_g), 32'(e.seg));
            chk("dp", 32'(dp), 32'(e.dp));
            chk("idx", 32'(digit_idx), 32'(e.idx));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    initial begin
        logic [15:0] rv;
        logic [3:0]  rdp;
        logic [3:0]  rbk;
        logic        rlz;
        int          n;

        model_reset();
        #12;
        chk_dark("reset");
        #1 clr_n = 1'b1;

        run(40, 1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 32 && !(m_mode == 2 && (m_t / R) % D == 1); i++)
            tick(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
        run(40, 1'b1, 16'h0005, 4'h0, 4'h0, 1'b0);
        run(40, 1'b1, 16'h0040, 4'b0100, 4'h0, 1'b1);
        run(40, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
        run(40, 1'b1, 16'h8888, 4'h0, 4'b0001, 1'b0);

        for (int i = 0; i < 32 && !(m_mode == 2 && (m_t / R) % D == 2); i++)
            tick(1'b1, 16'h3C7E, 4'b1010, 4'h0, 1'b0);
        run(3, 1'b0, 16'h3C7E, 4'b1010, 4'h0, 1'b0);
        run(40, 1'b1, 16'hD9B0, 4'b0001, 4'h0, 1'b0);

        for (int p = 0; p < 40; p++) begin
            rv = 16'($urandom);
            for (int j = 0; j < D; j++) if ($urandom_range(0, 1) == 0) rv[4*j +: 4] = 4'h0;
            rdp = 4'($urandom);
            rbk = 4'h0;
            for (int j = 0; j < D; j++) rbk[j] = ($urandom_range(0, 3) == 0);
            rlz = 1'($urandom);
            n = $urandom_range(5, 50);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 9) == 0) rv = 16'($urandom);
                tick($urandom_range(0, 19) != 0, rv, rdp, rbk, rlz);
            end
        end

        run(22, 1'b1, 16'h4321, 4'h0, 4'h0, 1'b0);
        #5 clr_n = 1'b0;
        #1 chk_dark("async_clr");
        #1 clr_n = 1'b1;
        model_reset();
        run(40, 1'b1, 16'h9A0B, 4'b0010, 4'h0, 1'b1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
